// File: rtl/logic_rs_pkg.sv
// logic_rs_pkg -- shared types and constants for the logic/shift reservation
// station.
//   * Machine-wide widths (word, opcode, ROB, physical register file).
//   * RS_ENTRY_DEFAULT: default station depth.
//   * rs_src_t / rs_disp_t / rs_entry_t: source operand, dispatch bundle and
//     stored entry payload.
//   * cdb_t: CDB writeback broadcast. exe_t: issued micro-op bundle.
//   * src_wake(): applies a CDB broadcast to one source operand.
package logic_rs_pkg;

  localparam int WORD_SIZE_P      = 32;
  localparam int WIDTH_OP         = 4;
  localparam int ROB_ENTRY        = 16;
  localparam int NUM_PHYS_REG     = 32;
  localparam int RS_ENTRY_DEFAULT = 4;

  localparam int TAG_W = $clog2(NUM_PHYS_REG);
  localparam int ROB_W = $clog2(ROB_ENTRY);

  typedef logic [WORD_SIZE_P-1:0] word_t;
  typedef logic [WIDTH_OP-1:0]    op_t;
  typedef logic [TAG_W-1:0]       tag_t;
  typedef logic [ROB_W-1:0]       rob_t;

  // Opcodes understood by the logic/shift functional unit.
  typedef enum logic [WIDTH_OP-1:0] {
    OP_AND = 4'd0,
    OP_OR  = 4'd1,
    OP_XOR = 4'd2,
    OP_NOR = 4'd3,
    OP_SLL = 4'd4,
    OP_SRL = 4'd5,
    OP_SRA = 4'd6
  } logic_op_e;

  typedef struct packed {
    logic  rdy;
    tag_t  tag;
    word_t val;
  } rs_src_t;

  // Dispatch bundle as presented by the rename/dispatch stage.
  typedef struct packed {
    logic    v;
    op_t     op;
    rs_src_t src1;
    rs_src_t src2;
    rob_t    rob_dest;
    tag_t    reg_dest;
  } rs_disp_t;

  // Stored entry payload. Entry valid bits are kept as a separate vector so
  // that only they need a reset.
  typedef struct packed {
    op_t     op;
    rs_src_t src1;
    rs_src_t src2;
    rob_t    rob_dest;
    tag_t    reg_dest;
  } rs_entry_t;

  // Common data bus writeback broadcast.
  typedef struct packed {
    logic  v;
    tag_t  dest;
    word_t result;
  } cdb_t;

  // Micro-op presented to the logic FU.
  typedef struct packed {
    op_t   op;
    word_t opnd1;
    word_t opnd2;
    rob_t  rob_dest;
    tag_t  reg_dest;
  } exe_t;

  // A not-yet-ready source whose producer tag is on the CDB captures the
  // broadcast value; ready sources are never overwritten.
  function automatic rs_src_t src_wake(input rs_src_t s, input cdb_t c);
    rs_src_t r;
    r = s;
    if (c.v && !s.rdy && (s.tag == c.dest)) begin
      r.rdy = 1'b1;
      r.val = c.result;
    end
    return r;
  endfunction

endpackage

// File: rtl/logic_rs_age_select.sv
// rs_age_select -- age matrix and oldest-ready selector for the station.
//   age_q[i][j] = 1 means entry j is older than entry i. A row is written
//   with the set of surviving valid entries when its entry is allocated; a
//   column (and the row) is cleared when its entry is freed.
// Ports:
//   clk_i, reset_i (async, active low), flush_i (clear whole matrix)
//   valid_i  registered entry valid vector
//   alloc_i  one-hot entry being allocated this cycle
//   free_i   one-hot entry being freed (issued) this cycle
//   req_i    entries eligible for issue (both sources ready)
//   grant_o  one-hot oldest eligible entry, grant_v_o = any grant
module rs_age_select #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         flush_i,
  input  logic [N-1:0] valid_i,
  input  logic [N-1:0] alloc_i,
  input  logic [N-1:0] free_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] grant_o,
  output logic         grant_v_o
);

  logic [N-1:0][N-1:0] age_q, age_d;

  // An entry wins when no eligible entry is older than it. Valid entries form
  // a total order, so at most one bit of grant_o is set.
  always_comb begin
    grant_o = '0;
    for (int i = 0; i < N; i++) begin
      grant_o[i] = req_i[i] && ((age_q[i] & req_i) == '0);
    end
    grant_v_o = |grant_o;
  end

  // NOTE: every signal written in an always_comb gets a default on entry, so
  // no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    age_d = age_q;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (alloc_i[i]) begin
          age_d[i][j] = valid_i[j] & ~free_i[j];
        end else if (free_i[i] || free_i[j]) begin
          age_d[i][j] = 1'b0;
        end
      end
    end
    if (flush_i) begin
      age_d = '0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/logic_rs.sv
// logic_rs -- reservation station for the logic/shift functional unit.
// Holds renamed micro-ops until both sources are ready, snoops the CDB for
// operands and issues the oldest ready entry, one per cycle, through a
// registered bundle.
// Optional feature: define LOGIC_RS_CDB_BYPASS_EN to forward a same-cycle CDB
// wakeup straight into select (issue one cycle earlier). Default build uses
// registered ready bits only.
// Ports:
//   clk_i, reset_i (async, active low), flush_i (squash everything)
//   disp_*   dispatch handshake and micro-op fields, disp_ready_o = free slot
//   cdb_*    CDB broadcast (valid, destination tag, result)
//   exe_v_o, opcode_o, operand1_o, operand2_o, rob_dest_o, reg_dest_o
//            registered issue bundle to the FU (data holds when exe_v_o = 0)
module logic_rs
  import logic_rs_pkg::*;
#(
  parameter int RS_ENTRY = RS_ENTRY_DEFAULT
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    flush_i,
  input  logic                    disp_v_i,
  output logic                    disp_ready_o,
  input  logic [WIDTH_OP-1:0]     disp_op_i,
  input  logic                    disp_src1_rdy_i,
  input  logic                    disp_src2_rdy_i,
  input  logic [TAG_W-1:0]        disp_src1_tag_i,
  input  logic [TAG_W-1:0]        disp_src2_tag_i,
  input  logic [WORD_SIZE_P-1:0]  disp_src1_val_i,
  input  logic [WORD_SIZE_P-1:0]  disp_src2_val_i,
  input  logic [ROB_W-1:0]        disp_rob_dest_i,
  input  logic [TAG_W-1:0]        disp_reg_dest_i,
  input  logic                    cdb_v_i,
  input  logic [TAG_W-1:0]        cdb_dest_i,
  input  logic [WORD_SIZE_P-1:0]  cdb_result_i,
  output logic                    exe_v_o,
  output logic [WIDTH_OP-1:0]     opcode_o,
  output logic [WORD_SIZE_P-1:0]  operand1_o,
  output logic [WORD_SIZE_P-1:0]  operand2_o,
  output logic [ROB_W-1:0]        rob_dest_o,
  output logic [TAG_W-1:0]        reg_dest_o
);

  cdb_t     cdb;
  rs_disp_t disp;
  logic     disp_fire;

  logic [RS_ENTRY-1:0] valid_q, valid_d;
  logic [RS_ENTRY-1:0] alloc_oh, free_oh, req, grant;
  logic                grant_v;

  rs_entry_t entry_q [RS_ENTRY];
  rs_entry_t entry_d [RS_ENTRY];
  rs_src_t   src1_eff [RS_ENTRY];
  rs_src_t   src2_eff [RS_ENTRY];

  logic exe_v_q, exe_v_d;
  exe_t exe_q, exe_d;

  assign cdb = '{v: cdb_v_i, dest: cdb_dest_i, result: cdb_result_i};

  // Dispatch sources pass through the same CDB snoop as resident entries.
  assign disp = '{
    v:        disp_v_i,
    op:       disp_op_i,
    src1:     src_wake('{rdy: disp_src1_rdy_i, tag: disp_src1_tag_i,
                         val: disp_src1_val_i}, cdb),
    src2:     src_wake('{rdy: disp_src2_rdy_i, tag: disp_src2_tag_i,
                         val: disp_src2_val_i}, cdb),
    rob_dest: disp_rob_dest_i,
    reg_dest: disp_reg_dest_i
  };

  // Readiness comes from registered occupancy only: an entry issuing this
  // cycle does not make room for a dispatch in the same cycle.
  assign disp_ready_o = ~&valid_q;
  assign disp_fire    = disp.v && disp_ready_o && !flush_i;

  // ~v & (v + 1) isolates the lowest clear bit: the lowest-index free entry.
  assign alloc_oh = disp_fire ? (~valid_q & (valid_q + RS_ENTRY'(1))) : '0;

  // Source view used by select and by the issue mux.
  always_comb begin
    for (int i = 0; i < RS_ENTRY; i++) begin
`ifdef LOGIC_RS_CDB_BYPASS_EN
      src1_eff[i] = src_wake(entry_q[i].src1, cdb);
      src2_eff[i] = src_wake(entry_q[i].src2, cdb);
`else
      src1_eff[i] = entry_q[i].src1;
      src2_eff[i] = entry_q[i].src2;
`endif
      req[i] = valid_q[i] && src1_eff[i].rdy && src2_eff[i].rdy;
    end
  end

  rs_age_select #(
    .N (RS_ENTRY)
  ) u_age_select (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .flush_i   (flush_i),
    .valid_i   (valid_q),
    .alloc_i   (alloc_oh),
    .free_i    (free_oh),
    .req_i     (req),
    .grant_o   (grant),
    .grant_v_o (grant_v)
  );

  // The granted entry leaves the station at the edge that loads it into the
  // issue register.
  assign free_oh = grant;

  always_comb begin
    exe_d = '0;
    for (int i = 0; i < RS_ENTRY; i++) begin
      if (grant[i]) begin
        exe_d = '{op:       entry_q[i].op,
                  opnd1:    src1_eff[i].val,
                  opnd2:    src2_eff[i].val,
                  rob_dest: entry_q[i].rob_dest,
                  reg_dest: entry_q[i].reg_dest};
      end
    end
    exe_v_d = grant_v && !flush_i;
  end

  always_comb begin
    for (int i = 0; i < RS_ENTRY; i++) begin
      entry_d[i]      = entry_q[i];
      entry_d[i].src1 = src_wake(entry_q[i].src1, cdb);
      entry_d[i].src2 = src_wake(entry_q[i].src2, cdb);
      if (alloc_oh[i]) begin
        entry_d[i] = '{op:       disp.op,
                       src1:     disp.src1,
                       src2:     disp.src2,
                       rob_dest: disp.rob_dest,
                       reg_dest: disp.reg_dest};
      end
    end
    valid_d = flush_i ? '0 : ((valid_q & ~free_oh) | alloc_oh);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      valid_q <= '0;
      exe_v_q <= 1'b0;
      exe_q   <= '0;
    end else begin
      valid_q <= valid_d;
      exe_v_q <= exe_v_d;
      if (exe_v_d) begin
        exe_q <= exe_d;
      end
    end
  end

  // NOTE: entry payload storage is deliberately left without reset; it is
  // only ever read behind a valid bit, and that bit is reset.
  always_ff @(posedge clk_i) begin
    entry_q <= entry_d;
  end

  assign exe_v_o    = exe_v_q;
  assign opcode_o   = exe_q.op;
  assign operand1_o = exe_q.opnd1;
  assign operand2_o = exe_q.opnd2;
  assign rob_dest_o = exe_q.rob_dest;
  assign reg_dest_o = exe_q.reg_dest;

endmodule

// File: tb/tb_logic_rs.sv
// tb_logic_rs -- self-checking bench for logic_rs.
// A queue-based reference model (oldest first) predicts the issue bundle and
// disp_ready_o every cycle; directed scenarios pin the model with literal
// expectations, followed by a randomized phase.
`timescale 1ns/1ps
module tb_logic_rs;
  import logic_rs_pkg::*;

  localparam int N = RS_ENTRY_DEFAULT;
`ifdef LOGIC_RS_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                   clk, rst_n, flush;
  logic                   disp_v, disp_ready;
  logic [WIDTH_OP-1:0]    disp_op;
  logic                   s1_rdy, s2_rdy;
  logic [TAG_W-1:0]       s1_tag, s2_tag;
  logic [WORD_SIZE_P-1:0] s1_val, s2_val;
  logic [ROB_W-1:0]       disp_rob;
  logic [TAG_W-1:0]       disp_rd;
  logic                   cdb_v;
  logic [TAG_W-1:0]       cdb_dest;
  logic [WORD_SIZE_P-1:0] cdb_result;
  logic                   exe_v;
  logic [WIDTH_OP-1:0]    opcode;
  logic [WORD_SIZE_P-1:0] opnd1, opnd2;
  logic [ROB_W-1:0]       rob_dest;
  logic [TAG_W-1:0]       reg_dest;

  logic_rs #(.RS_ENTRY(N)) dut (
    .clk_i           (clk),
    .reset_i         (rst_n),
    .flush_i         (flush),
    .disp_v_i        (disp_v),
    .disp_ready_o    (disp_ready),
    .disp_op_i       (disp_op),
    .disp_src1_rdy_i (s1_rdy),
    .disp_src2_rdy_i (s2_rdy),
    .disp_src1_tag_i (s1_tag),
    .disp_src2_tag_i (s2_tag),
    .disp_src1_val_i (s1_val),
    .disp_src2_val_i (s2_val),
    .disp_rob_dest_i (disp_rob),
    .disp_reg_dest_i (disp_rd),
    .cdb_v_i         (cdb_v),
    .cdb_dest_i      (cdb_dest),
    .cdb_result_i    (cdb_result),
    .exe_v_o         (exe_v),
    .opcode_o        (opcode),
    .operand1_o      (opnd1),
    .operand2_o      (opnd2),
    .rob_dest_o      (rob_dest),
    .reg_dest_o      (reg_dest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [WIDTH_OP-1:0]    op;
    bit                     r1, r2;
    logic [TAG_W-1:0]       t1, t2;
    logic [WORD_SIZE_P-1:0] v1, v2;
    logic [ROB_W-1:0]       rob;
    logic [TAG_W-1:0]       rd;
  } m_uop_t;

  m_uop_t                 mq[$];     // resident ops, oldest at index 0
  bit                     m_v   = 1'b0;
  logic [WIDTH_OP-1:0]    m_op  = '0;
  logic [WORD_SIZE_P-1:0] m_o1  = '0;
  logic [WORD_SIZE_P-1:0] m_o2  = '0;
  logic [ROB_W-1:0]       m_rob = '0;
  logic [TAG_W-1:0]       m_rd  = '0;
  bit                     chk_en = 1'b0;

  // Operand usable by select this cycle.
  function automatic bit usable(input bit r, input logic [TAG_W-1:0] t);
    return r || (BYP && cdb_v && (t == cdb_dest));
  endfunction

  task automatic model_step();
    int     sel;
    bit     fire;
    m_uop_t u;
    fire = disp_v && (mq.size() < N) && !flush;
    sel  = -1;
    for (int i = 0; i < mq.size(); i++) begin
      if (sel < 0 && usable(mq[i].r1, mq[i].t1) && usable(mq[i].r2, mq[i].t2)) sel = i;
    end
    if (flush) begin
      mq.delete();
      m_v = 1'b0;
    end else begin
      m_v = (sel >= 0);
      if (sel >= 0) begin
        u     = mq[sel];
        m_op  = u.op;
        m_o1  = u.r1 ? u.v1 : cdb_result;
        m_o2  = u.r2 ? u.v2 : cdb_result;
        m_rob = u.rob;
        m_rd  = u.rd;
        mq.delete(sel);
      end
      for (int i = 0; i < mq.size(); i++) begin
        u = mq[i];
        if (!u.r1 && cdb_v && u.t1 == cdb_dest) begin u.r1 = 1'b1; u.v1 = cdb_result; end
        if (!u.r2 && cdb_v && u.t2 == cdb_dest) begin u.r2 = 1'b1; u.v2 = cdb_result; end
        mq[i] = u;
      end
      if (fire) begin
        u.op = disp_op; u.r1 = s1_rdy; u.t1 = s1_tag; u.v1 = s1_val;
        u.r2 = s2_rdy; u.t2 = s2_tag; u.v2 = s2_val; u.rob = disp_rob; u.rd = disp_rd;
        if (!u.r1 && cdb_v && u.t1 == cdb_dest) begin u.r1 = 1'b1; u.v1 = cdb_result; end
        if (!u.r2 && cdb_v && u.t2 == cdb_dest) begin u.r2 = 1'b1; u.v2 = cdb_result; end
        mq.push_back(u);
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_v = 1'b0; m_op = '0; m_o1 = '0; m_o2 = '0; m_rob = '0; m_rd = '0;
    end else begin
      model_step();
    end
  end

  // Compare process: outputs sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_exe_v",    64'(exe_v),      64'(m_v));
      check("cmp_opcode",   64'(opcode),     64'(m_op));
      check("cmp_operand1", 64'(opnd1),      64'(m_o1));
      check("cmp_operand2", 64'(opnd2),      64'(m_o2));
      check("cmp_rob_dest", 64'(rob_dest),   64'(m_rob));
      check("cmp_reg_dest", 64'(reg_dest),   64'(m_rd));
      check("cmp_ready",    64'(disp_ready), 64'(mq.size() < N));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_disp(input int op, input int r1, input int t1, input int v1,
                            input int r2, input int t2, input int v2,
                            input int rob, input int rd);
    disp_v   = 1'b1;
    disp_op  = WIDTH_OP'(op);
    s1_rdy   = r1 != 0;  s1_tag = TAG_W'(t1); s1_val = WORD_SIZE_P'(v1);
    s2_rdy   = r2 != 0;  s2_tag = TAG_W'(t2); s2_val = WORD_SIZE_P'(v2);
    disp_rob = ROB_W'(rob);
    disp_rd  = TAG_W'(rd);
  endtask

  task automatic broadcast(input int tag, input int val);
    cdb_v      = 1'b1;
    cdb_dest   = TAG_W'(tag);
    cdb_result = WORD_SIZE_P'(val);
  endtask

  // Waits on falling edges for exe_v; n = edges waited (n == max on timeout).
  task automatic wait_exe(input int max, output int n);
    n = 0;
    while (exe_v !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; flush = 1'b0; disp_v = 1'b0; disp_op = '0;
    s1_rdy = 1'b0; s2_rdy = 1'b0; s1_tag = '0; s2_tag = '0; s1_val = '0; s2_val = '0;
    disp_rob = '0; disp_rd = '0; cdb_v = 1'b0; cdb_dest = '0; cdb_result = '0;
    repeat (3) step();
    check("rst_exe_v",    64'(exe_v),      64'd0);
    check("rst_ready",    64'(disp_ready), 64'd1);
    check("rst_operand1", 64'(opnd1),      64'd0);
    check("rst_rob_dest", 64'(rob_dest),   64'd0);
    chk_en = 1'b1;
    rst_n  = 1'b1;

    // 1: ready AND issues two cycles after dispatch.
    drive_disp(OP_AND, 1, 0, 'h00F0, 1, 0, 'h0FF0, 3, 9);
    step(); disp_v = 1'b0;
    check("s1_not_yet", 64'(exe_v), 64'd0);
    step();
    check("s1_exe_v",   64'(exe_v),    64'd1);
    check("s1_opcode",  64'(opcode),   64'(OP_AND));
    check("s1_op1",     64'(opnd1),    64'h00F0);
    check("s1_op2",     64'(opnd2),    64'h0FF0);
    check("s1_rob",     64'(rob_dest), 64'd3);
    check("s1_reg",     64'(reg_dest), 64'd9);
    step();
    check("s1_single",  64'(exe_v),    64'd0);

    // 2: src2 waits on tag 5, broadcast three cycles after dispatch.
    drive_disp(OP_OR, 1, 0, 'hAAAA, 0, 5, 0, 4, 10);
    step(); disp_v = 1'b0;
    step(); step();
    broadcast(5, 'h1234);
    step(); cdb_v = 1'b0;
    check("s2_plus1", 64'(exe_v), 64'(BYP));
    step();
    check("s2_plus2", 64'(exe_v), 64'(!BYP));
    check("s2_op2",   64'(opnd2), 64'h1234);
    check("s2_op1",   64'(opnd1), 64'hAAAA);
    check("s2_rob",   64'(rob_dest), 64'd4);

    // 3: fill the station, extra dispatch ignored, one broadcast drains in order.
    for (int i = 0; i < N; i++) begin
      drive_disp(OP_XOR, 0, 12, 0, 0, 12, 0, 8 + i, i);
      step();
    end
    check("s3_full", 64'(disp_ready), 64'd0);
    drive_disp(OP_AND, 1, 0, 1, 1, 0, 2, 15, 15);
    step(); step();
    check("s3_still_full", 64'(disp_ready), 64'd0);
    disp_v = 1'b0;
    broadcast(12, 'hBEEF);
    step(); cdb_v = 1'b0;
    wait_exe(8, n);
    check("s3_wait_timeout", 64'(n < 8), 64'd1);
    check("s3_latency", 64'(n), 64'(BYP ? 0 : 1));
    for (int i = 0; i < N; i++) begin
      check("s3_issue_v",   64'(exe_v),    64'd1);
      check("s3_issue_rob", 64'(rob_dest), 64'(8 + i));
      check("s3_issue_op1", 64'(opnd1),    64'hBEEF);
      step();
    end
    check("s3_drained", 64'(exe_v), 64'd0);
    step(); step();
    check("s3_extra_dropped", 64'(exe_v), 64'd0);

    // 4: dispatch snoop captures tag 7 in the dispatch cycle.
    broadcast(7, 'h7777);
    drive_disp(OP_SLL, 0, 7, 0, 1, 0, 4, 5, 7);
    step(); cdb_v = 1'b0; disp_v = 1'b0;
    check("s4_plus1", 64'(exe_v), 64'd0);
    step();
    check("s4_plus2", 64'(exe_v), 64'd1);
    check("s4_op1",   64'(opnd1), 64'h7777);
    check("s4_op2",   64'(opnd2), 64'h4);

    // 5: flush with three resident entries and one op in the issue register.
    for (int i = 0; i < 3; i++) begin
      drive_disp(OP_OR, 0, 20, 0, 1, 0, 5, i, i);
      step();
    end
    drive_disp(OP_AND, 1, 0, 'hD, 1, 0, 'hE, 6, 6);
    step(); disp_v = 1'b0;
    step();
    check("s5_pre_v",   64'(exe_v),    64'd1);
    check("s5_pre_rob", 64'(rob_dest), 64'd6);
    flush = 1'b1;
    step(); flush = 1'b0;
    check("s5_flush_v",     64'(exe_v),      64'd0);
    check("s5_flush_ready", 64'(disp_ready), 64'd1);
    broadcast(20, 'h2020);
    step(); cdb_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("s5_no_issue", 64'(exe_v), 64'd0);
      step();
    end

    // 6: asynchronous reset while an op is on the issue port.
    for (int i = 0; i < 3; i++) begin
      drive_disp(OP_XOR, 1, 0, 'h10 + i, 1, 0, 'h20, 1 + i, 1 + i);
      step();
    end
    disp_v = 1'b0;
    wait_exe(6, n);
    check("s6_wait_timeout", 64'(n < 6), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("s6_async_v",   64'(exe_v),    64'd0);
    check("s6_async_op1", 64'(opnd1),    64'd0);
    check("s6_async_rob", 64'(rob_dest), 64'd0);
    step();
    rst_n = 1'b1;
    check("s6_ready", 64'(disp_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("s6_empty", 64'(exe_v), 64'd0);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      disp_v     = ($urandom_range(0, 9) < 6);
      disp_op    = WIDTH_OP'($urandom_range(0, 15));
      s1_rdy     = ($urandom_range(0, 2) == 0);
      s2_rdy     = ($urandom_range(0, 2) == 0);
      s1_tag     = TAG_W'($urandom_range(0, 7));
      s2_tag     = TAG_W'($urandom_range(0, 7));
      s1_val     = WORD_SIZE_P'($urandom);
      s2_val     = WORD_SIZE_P'($urandom);
      disp_rob   = ROB_W'($urandom_range(0, ROB_ENTRY - 1));
      disp_rd    = TAG_W'($urandom_range(0, NUM_PHYS_REG - 1));
      cdb_v      = ($urandom_range(0, 1) == 1);
      cdb_dest   = TAG_W'($urandom_range(0, 7));
      cdb_result = WORD_SIZE_P'($urandom);
      flush      = ($urandom_range(0, 99) < 2);
      step();
    end
    disp_v = 1'b0; cdb_v = 1'b0; flush = 1'b0;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/logic_rs.md
# logic_rs

Reservation station feeding the logic/shift functional unit in the execute stage. It accepts renamed logic/shift micro-ops from dispatch, holds them until both source operands are available, and snoops the common data bus (CDB) to capture operands. It issues the oldest ready entry, one per cycle, as a registered `exe_v`/opcode/operands/destination bundle on the logic FU's input port.

## Interface
- `RS_ENTRY`, 4: number of station entries, power of two, ≥2.
- `WORD_SIZE_P`, `WIDTH_OP`, `ROB_ENTRY`, `NUM_PHYS_REG`: shared package constants, not overridden here.

- `clk_i` in 1: single clock.
- `reset_i` in 1: asynchronous, active-low reset.
- `flush_i` in 1: squash all entries and the issue register.
- `disp_v_i` in 1: dispatch valid.
- `disp_ready_o` out 1: a free entry exists.
- `disp_op_i` in `WIDTH_OP`: opcode.
- `disp_src1_rdy_i`, `disp_src2_rdy_i` in 1: operand already valid.
- `disp_src1_tag_i`, `disp_src2_tag_i` in `$clog2(NUM_PHYS_REG)`: producer physical register.
- `disp_src1_val_i`, `disp_src2_val_i` in `WORD_SIZE_P`: operand value, meaningful when ready.
- `disp_rob_dest_i` in `$clog2(ROB_ENTRY)`; `disp_reg_dest_i` in `$clog2(NUM_PHYS_REG)`.
- `cdb_v_i` in 1; `cdb_dest_i` in `$clog2(NUM_PHYS_REG)`; `cdb_result_i` in `WORD_SIZE_P`: CDB broadcast.
- `exe_v_o` out 1: issue valid to the FU.
- `opcode_o`, `operand1_o`, `operand2_o`, `rob_dest_o`, `reg_dest_o` out: issued micro-op, widths as the matching dispatch fields.

## Operation
- Entry state: valid, opcode, per-source {rdy, tag, val}, rob_dest, reg_dest.
- Dispatch: a handshake fires when `disp_v_i && disp_ready_o`. It writes the lowest-index free entry. `disp_v_i` without ready is ignored; dispatch must hold.
- Dispatch snoop: if a source is not ready and the CDB matches its tag in the same cycle, the entry is written ready with `cdb_result_i`.
- Wakeup: every valid, not-ready source whose tag equals `cdb_dest_i` while `cdb_v_i` is high captures `cdb_result_i` and sets rdy. Both sources may wake on one broadcast.
- Select: among entries with both sources ready, pick the oldest. Age is tracked by an `RS_ENTRY`×`RS_ENTRY` age matrix: row set on allocate, column cleared on free. The selected entry is freed at the same clock edge its contents load the issue register.
- Issue register: `exe_v_o` is high for one cycle per issued op. Otherwise `exe_v_o` is 0 and the data outputs hold their last values. There is no FU backpressure: the FU accepts every cycle.
- `disp_ready_o` is computed from registered occupancy: high iff fewer than `RS_ENTRY` entries are valid. A same-cycle issue does not free a slot for a same-cycle dispatch.
- Flush: at the next edge, all entries are invalidated, the age matrix is cleared and `exe_v_o` is 0. Flush overrides a same-cycle dispatch, which is dropped.
- Reset: all entries invalid, the age matrix is zero, `exe_v_o`=0, all data outputs 0, and `disp_ready_o`=1.

## Timing
- Dispatch at cycle t with both sources ready: entry valid at t+1, selected at t+1, `exe_v_o` high at t+2.
- CDB wakeup at cycle t of a resident entry: see Configuration.
- Throughput: one issue per cycle. A full station drains in `RS_ENTRY` cycles when all entries are ready.

## Configuration
- `LOGIC_RS_CDB_BYPASS_EN` defined: wakeup is forwarded combinationally into select. An entry completed by the CDB at cycle t may issue with `exe_v_o` high at t+1, with the CDB value on the operand.
- Undefined: select sees registered ready bits only. The same entry issues with `exe_v_o` high at t+2. Functional results are identical.

## Structure
- Shared package: `rs_entry_t`, `rs_disp_t`, and the `RS_ENTRY` default constant alongside the existing ROB/CDB writeback types.
- Sub-module: `rs_age_select` holds the age matrix and returns a one-hot oldest-ready grant plus a valid flag.

## Test plan
- Reset deasserted, dispatch AND with src1=0x00F0 and src2=0x0FF0 both ready → `exe_v_o`=1 two cycles later with opcode AND, operands 0x00F0/0x0FF0, and matching rob/reg dest.
- Dispatch with src2 not ready (tag 5); CDB broadcasts tag 5, value 0x1234, 3 cycles later → issue with operand2=0x1234 at +1 (bypass) or +2 (no bypass) after the broadcast.
- Fill all 4 entries with not-ready ops → `disp_ready_o`=0 and extra `disp_v_i` is ignored. Wake all sources with one broadcast → 4 consecutive issues in dispatch order.
- Dispatch with src1 tag 7 not ready while CDB broadcasts tag 7 the same cycle → entry captured ready and issues at t+2 without a further broadcast.
- Flush with 3 entries resident and one op in the issue register → next cycle `exe_v_o`=0, `disp_ready_o`=1, and no later issue of the flushed ops.
- Drive `reset_i` low mid-stream with `exe_v_o` high → `exe_v_o` and the outputs go to 0 immediately (asynchronously), and the station is empty after release.
